// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: instruction formats, base opcodes, field widths
// and the loader FSM state encoding.
package riscv_pkg;

  localparam int XLEN  = 32;
  localparam int OPC_W = 7;
  localparam int F3_W  = 3;
  localparam int F7_W  = 7;
  localparam int REG_W = 5;
  localparam int FMT_W = 3;

  typedef enum logic [FMT_W-1:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } inst_fmt_e;

  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } enc_state_e;

  function automatic logic fmt_is_legal(input logic [FMT_W-1:0] fmt);
    return fmt <= FMT_J;
  endfunction

endpackage

// File: rtl/inst_encoder_if.sv
// Decoded-field tuple channel into the encoder, valid/ready handshake.
// master = tuple source, slave = encoder.
interface inst_encoder_if;
  import riscv_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [FMT_W-1:0]  fmt;
  logic [OPC_W-1:0]  opcode;
  logic [F3_W-1:0]   func3;
  logic [F7_W-1:0]   func7;
  logic [REG_W-1:0]  rd;
  logic [REG_W-1:0]  rs1;
  logic [REG_W-1:0]  rs2;
  logic [XLEN-1:0]   imm;

  modport master (
    output in_valid, fmt, opcode, func3, func7, rd, rs1, rs2, imm,
    input  in_ready
  );

  modport slave (
    input  in_valid, fmt, opcode, func3, func7, rd, rs1, rs2, imm,
    output in_ready
  );
endinterface

// File: rtl/inst_encoder_core.sv
// Combinational RV32I field packer; zero latency, no state.
// Flags illegal formats and B/J immediates with bit 0 set.
module inst_encode_core
  import riscv_pkg::*;
(
  input  logic [FMT_W-1:0] fmt,
  input  logic [OPC_W-1:0] opcode,
  input  logic [F3_W-1:0]  func3,
  input  logic [F7_W-1:0]  func7,
  input  logic [REG_W-1:0] rd,
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  input  logic [XLEN-1:0]  imm,
  output logic [XLEN-1:0]  word,
  output logic             illegal,
  output logic             misaligned
);

  always_comb begin
    word       = '0;
    illegal    = !fmt_is_legal(fmt);
    misaligned = 1'b0;
    case (fmt)
      FMT_R: word = {func7, rs2, rs1, func3, rd, opcode};
      FMT_I: word = {imm[11:0], rs1, func3, rd, opcode};
      FMT_S: word = {imm[11:5], rs2, rs1, func3, imm[4:0], opcode};
      FMT_B: begin
        word       = {imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11], opcode};
        misaligned = imm[0];
      end
      FMT_U: word = {imm[31:12], rd, opcode};
      FMT_J: begin
        word       = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        misaligned = imm[0];
      end
      default: word = '0;
    endcase
  end

endmodule

// File: rtl/inst_encoder.sv
// Program loader: packs accepted tuples and writes them one per cycle into imem.
// Write appears the cycle after accept; in_ready drops outside LOAD or when full.
module inst_encoder
  import riscv_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH = 1024,
  parameter logic [31:0] BASE_ADDR  = 32'h0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         finish,
  inst_encoder_if.slave                in_if,
  output logic                         imem_we,
  output logic [31:0]                  imem_addr,
  output logic [31:0]                  imem_wdata,
  output logic [$clog2(IMEM_DEPTH):0]  inst_count,
  output logic                         done,
  output logic                         err
);

  localparam int CNT_W = $clog2(IMEM_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(IMEM_DEPTH);
  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(IMEM_DEPTH - 1);

  enc_state_e      state;
  logic [XLEN-1:0] enc_word;
  logic            enc_illegal;
  logic            enc_misaligned;
  logic            accept;
  logic            write_ok;

  inst_encode_core u_core (
    .fmt        (in_if.fmt),
    .opcode     (in_if.opcode),
    .func3      (in_if.func3),
    .func7      (in_if.func7),
    .rd         (in_if.rd),
    .rs1        (in_if.rs1),
    .rs2        (in_if.rs2),
    .imm        (in_if.imm),
    .word       (enc_word),
    .illegal    (enc_illegal),
    .misaligned (enc_misaligned)
  );

  // inst_count doubles as the write pointer; it never exceeds IMEM_DEPTH.
  assign in_if.in_ready = (state == S_LOAD) && (inst_count < DEPTH_C);
  assign accept         = in_if.in_valid && in_if.in_ready;
  assign write_ok       = accept && !enc_illegal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      inst_count <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state      <= S_LOAD;
            inst_count <= '0;
            err        <= 1'b0;
            done       <= 1'b0;
          end
        end
        S_LOAD: begin
          if (accept && enc_illegal) err <= 1'b1;
          if (write_ok) begin
            imem_we    <= 1'b1;
            imem_addr  <= BASE_ADDR + (32'(inst_count) << 2);
            imem_wdata <= enc_word;
            inst_count <= inst_count + 1'b1;
            if (enc_misaligned) err <= 1'b1;
          end
          // done rises alongside the final write so the sink sees both together
          if (finish || (write_ok && inst_count == LAST_C)) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder with a 4-word memory at base 0x100.
module tb_inst_encoder;
  import riscv_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        finish = 1'b0;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic [2:0]  inst_count;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;

  inst_encoder_if enc_if ();

  inst_encoder #(.IMEM_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .finish     (finish),
    .in_if      (enc_if),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .inst_count (inst_count),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [4:0] d, input logic [4:0] s1,
                       input logic [4:0] s2, input logic [31:0] im, input logic v);
    enc_if.fmt = f; enc_if.opcode = op; enc_if.func3 = f3; enc_if.func7 = f7;
    enc_if.rd = d; enc_if.rs1 = s1; enc_if.rs2 = s2; enc_if.imm = im;
    enc_if.in_valid = v;
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic pulse_finish();
    finish = 1'b1; step(); finish = 1'b0;
  endtask

  task automatic test_reset();
    drive(3'd0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0);
    step(); step();
    checks++; if (imem_we !== 1'b0) begin errors++; $display("FAIL rst_we got %b want 0", imem_we); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got %h want 0", imem_addr); end
    checks++; if (imem_wdata !== 32'h0) begin errors++; $display("FAIL rst_wdata got %h want 0", imem_wdata); end
    checks++; if (inst_count !== 3'd0) begin errors++; $display("FAIL rst_count got %0d want 0", inst_count); end
    checks++; if ({done, err} !== 2'b00) begin errors++; $display("FAIL rst_done_err got %b want 00", {done, err}); end
    checks++; if (enc_if.in_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b want 0", enc_if.in_ready); end
    rst = 1'b0;
    step();
    checks++; if (enc_if.in_ready !== 1'b0) begin errors++; $display("FAIL idle_ready got %b want 0", enc_if.in_ready); end
  endtask

  task automatic test_r();
    pulse_start();
    checks++; if (enc_if.in_ready !== 1'b1) begin errors++; $display("FAIL load_ready got %b want 1", enc_if.in_ready); end
    drive(3'd0, 7'b0110011, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1);
    step();
    enc_if.in_valid = 1'b0;
    checks++; if (imem_we !== 1'b1) begin errors++; $display("FAIL r_we got %b want 1", imem_we); end
    checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL r_addr got %h want 00000100", imem_addr); end
    checks++; if (imem_wdata !== 32'h002081B3) begin errors++; $display("FAIL r_word got %h want 002081b3", imem_wdata); end
    checks++; if (inst_count !== 3'd1) begin errors++; $display("FAIL r_count got %0d want 1", inst_count); end
    step();
    checks++; if (imem_we !== 1'b0) begin errors++; $display("FAIL r_we_pulse got %b want 0", imem_we); end
  endtask

  task automatic test_i_u();
    drive(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'hFFFFFFFF, 1'b1);
    step();
    checks++; if (imem_wdata !== 32'hFFF00293) begin errors++; $display("FAIL i_word got %h want fff00293", imem_wdata); end
    checks++; if (imem_addr !== 32'h104) begin errors++; $display("FAIL i_addr got %h want 00000104", imem_addr); end
    drive(3'd4, 7'b0110111, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h12345000, 1'b1);
    step();
    enc_if.in_valid = 1'b0;
    checks++; if (imem_wdata !== 32'h123450B7) begin errors++; $display("FAIL u_word got %h want 123450b7", imem_wdata); end
    checks++; if (imem_addr !== 32'h108) begin errors++; $display("FAIL u_addr got %h want 00000108", imem_addr); end
    checks++; if (inst_count !== 3'd3) begin errors++; $display("FAIL u_count got %0d want 3", inst_count); end
    pulse_finish();
    checks++; if ({done, enc_if.in_ready} !== 2'b10) begin errors++; $display("FAIL fin_done_ready got %b want 10", {done, enc_if.in_ready}); end
    checks++; if (inst_count !== 3'd3) begin errors++; $display("FAIL fin_count_hold got %0d want 3", inst_count); end
  endtask

  task automatic test_back_to_back();
    pulse_start();
    checks++; if ({done, inst_count} !== 4'b0000) begin errors++; $display("FAIL restart got %b want 0000", {done, inst_count}); end
    drive(3'd2, 7'b0100011, 3'b010, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b1);
    step();
    checks++; if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 32'h100, 32'h0020A423}) begin errors++; $display("FAIL sw got %b %h %h want 1 00000100 0020a423", imem_we, imem_addr, imem_wdata); end
    drive(3'd3, 7'b1100011, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd8, 1'b1);
    step();
    checks++; if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 32'h104, 32'h00000463}) begin errors++; $display("FAIL beq got %b %h %h want 1 00000104 00000463", imem_we, imem_addr, imem_wdata); end
    drive(3'd5, 7'b1101111, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b1);
    step();
    enc_if.in_valid = 1'b0;
    checks++; if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 32'h108, 32'h001000EF}) begin errors++; $display("FAIL jal got %b %h %h want 1 00000108 001000ef", imem_we, imem_addr, imem_wdata); end
    checks++; if (inst_count !== 3'd3) begin errors++; $display("FAIL b2b_count got %0d want 3", inst_count); end
  endtask

  task automatic test_full();
    int nwr;
    logic [31:0] last;
    nwr = 0;
    last = 32'h0;
    pulse_finish();
    pulse_start();
    for (int c = 0; c < 8; c++) begin
      drive(3'd1, 7'b0010011, 3'd0, 7'd0, 5'(c + 1), 5'd0, 5'd0, 32'(c), c < 6);
      step();
      if (imem_we === 1'b1) begin
        checks++; if (imem_addr !== BASE + 32'(4 * nwr)) begin errors++; $display("FAIL full_addr got %h want %h", imem_addr, BASE + 32'(4 * nwr)); end
        nwr++;
        last = imem_addr;
        if (nwr == 4) begin
          checks++; if ({enc_if.in_ready, done} !== 2'b01) begin errors++; $display("FAIL full_ready_done got %b want 01", {enc_if.in_ready, done}); end
        end
      end
    end
    enc_if.in_valid = 1'b0;
    checks++; if (nwr != 4) begin errors++; $display("FAIL full_writes got %0d want 4", nwr); end
    checks++; if (last !== 32'h10C) begin errors++; $display("FAIL full_last got %h want 0000010c", last); end
    checks++; if ({done, inst_count} !== 4'b1100) begin errors++; $display("FAIL full_done_count got %b want 1100", {done, inst_count}); end
  endtask

  task automatic test_errors();
    pulse_start();
    drive(3'd7, 7'b0110011, 3'd0, 7'd0, 5'd1, 5'd1, 5'd1, 32'd0, 1'b1);
    step();
    enc_if.in_valid = 1'b0;
    checks++; if ({imem_we, err, inst_count} !== 5'b01000) begin errors++; $display("FAIL illegal got %b want 01000", {imem_we, err, inst_count}); end
    pulse_start();
    checks++; if ({err, enc_if.in_ready} !== 2'b11) begin errors++; $display("FAIL start_in_load got %b want 11", {err, enc_if.in_ready}); end
    drive(3'd5, 7'b1101111, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd3, 1'b1);
    step();
    enc_if.in_valid = 1'b0;
    checks++; if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 32'h100, 32'h002000EF}) begin errors++; $display("FAIL jal_odd got %b %h %h want 1 00000100 002000ef", imem_we, imem_addr, imem_wdata); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", err); end
    pulse_finish();
    pulse_start();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clear got %b want 0", err); end
    drive(3'd5, 7'b1101111, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd3, 1'b1);
    step();
    enc_if.in_valid = 1'b0;
    checks++; if ({err, inst_count} !== 4'b1001) begin errors++; $display("FAIL misalign got %b want 1001", {err, inst_count}); end
  endtask

  task automatic test_finish_accept();
    drive(3'd0, 7'b0110011, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1);
    finish = 1'b1;
    step();
    finish = 1'b0;
    enc_if.in_valid = 1'b0;
    checks++; if ({imem_we, done} !== 2'b11) begin errors++; $display("FAIL fin_acc_we_done got %b want 11", {imem_we, done}); end
    checks++; if ({imem_addr, imem_wdata} !== {32'h104, 32'h002081B3}) begin errors++; $display("FAIL fin_acc_word got %h %h want 00000104 002081b3", imem_addr, imem_wdata); end
    step();
    checks++; if ({imem_we, enc_if.in_ready, done, inst_count} !== 6'b001010) begin errors++; $display("FAIL fin_acc_after got %b want 001010", {imem_we, enc_if.in_ready, done, inst_count}); end
  endtask

  task automatic test_rst_mid();
    pulse_start();
    drive(3'd4, 7'b0110111, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h12345000, 1'b1);
    step();
    enc_if.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++; if ({imem_we, done, err, enc_if.in_ready} !== 4'b0000) begin errors++; $display("FAIL rst_mid_flags got %b want 0000", {imem_we, done, err, enc_if.in_ready}); end
    checks++; if ({imem_addr, imem_wdata, inst_count} !== 67'd0) begin errors++; $display("FAIL rst_mid_regs got %h %h %0d want 0 0 0", imem_addr, imem_wdata, inst_count); end
    step();
    rst = 1'b0;
    drive(3'd4, 7'b0110111, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h12345000, 1'b1);
    step();
    enc_if.in_valid = 1'b0;
    checks++; if ({imem_we, enc_if.in_ready, inst_count} !== 5'b00000) begin errors++; $display("FAIL rst_mid_idle got %b want 00000", {imem_we, enc_if.in_ready, inst_count}); end
  endtask

  initial begin
    test_reset();
    test_r();
    test_i_u();
    test_back_to_back();
    test_full();
    test_errors();
    test_finish_accept();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_encoder.md
# inst_encoder

Instruction encoder and program loader, the write-side counterpart of the decode stage: it accepts decoded instruction fields (format, opcode, func3, func7, rd, rs1, rs2, immediate) over a valid/ready handshake, packs them into 32-bit RV32I instruction words and writes them sequentially into instruction memory. It sits between a boot/test source and the instruction-memory write port, ahead of fetch.

## Interface
- IMEM_DEPTH, 1024: instruction-memory capacity in 32-bit words (power of two)
- BASE_ADDR, 32'h0: byte address of the first word written

- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin a load session (clears pointer and error)
- finish  in  1  end the current session
- in_valid  in  1  field tuple valid
- in_ready  out  1  encoder accepts a tuple this cycle
- fmt  in  3  format: 0 R, 1 I, 2 S, 3 B, 4 U, 5 J; 6–7 illegal
- opcode  in  7;  func3  in  3;  func7  in  7
- rd, rs1, rs2  in  5 each
- imm  in  32  immediate, sign-extended byte offset
- imem_we  out  1  write strobe
- imem_addr  out  32  byte address of write
- imem_wdata  out  32  encoded instruction
- inst_count  out  $clog2(IMEM_DEPTH)+1  words written this session
- done  out  1  session finished
- err  out  1  sticky error flag

## Operation
- FSM states IDLE, LOAD, DONE; reset → IDLE.
- IDLE: in_ready=0; start → LOAD, ptr←0, err←0.
- LOAD: in_ready = (ptr < IMEM_DEPTH). Accept on in_valid && in_ready.
- Legal fmt: word encoded, written at BASE_ADDR + 4·ptr, ptr increments.
- Illegal fmt (6, 7): tuple consumed, nothing written, ptr unchanged, err←1.
- Encodings, unused fields ignored:
  - R: {func7, rs2, rs1, func3, rd, opcode}
  - I: {imm[11:0], rs1, func3, rd, opcode}
  - S: {imm[11:5], rs2, rs1, func3, imm[4:0], opcode}
  - B: {imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11], opcode}
  - U: {imm[31:12], rd, opcode}
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}
- B/J with imm[0]=1: word written with imm[0] dropped, err←1. No range check on imm; upper bits silently truncated.
- LOAD → DONE on finish, or when ptr reaches IMEM_DEPTH after an accept.
- DONE: in_ready=0, done=1; start → LOAD (new session). start in LOAD ignored; finish in IDLE/DONE ignored.
- inst_count mirrors ptr.

## Timing
- Reset values: state IDLE, in_ready 0, imem_we 0, imem_addr 0, imem_wdata 0, inst_count 0, done 0, err 0.
- Latency: accept at edge k → imem_we=1 with addr/wdata valid for the cycle after edge k, single cycle. Throughput one word per cycle.
- imem_we, imem_addr, imem_wdata, inst_count, done, err all registered.
- finish together with an accepted tuple: tuple written, then DONE. done rises in the same cycle as that final imem_we.
- Full: the accept that makes ptr = IMEM_DEPTH drops in_ready the next cycle and enters DONE. No wrap-around.
- rst mid-session: pending write dropped (imem_we 0 immediately), all state cleared.

## Structure
- Shared package riscv_pkg: inst_fmt_e enum (FMT_R…FMT_J), RV32I opcode constants, and the field-width localparams used by the decoder.
- Sub-module inst_encode_core: purely combinational fields → word packing plus illegal/misaligned flags. The top holds the FSM, pointer and output registers.

## Test plan
- R: fmt=0 opcode 0110011, func3 0, func7 0, rd 3, rs1 1, rs2 2 → imem_wdata 32'h002081B3 at addr BASE_ADDR, inst_count 1.
- I: addi opcode 0010011, rd 5, rs1 0, imm 32'hFFFFFFFF → 32'hFFF00293. U: lui opcode 0110111, rd 1, imm 32'h12345000 → 32'h123450B7.
- S/B/J back-to-back, in_valid held high for 3 cycles:
  - sw (opcode 0100011, func3 010, rs1 1, rs2 2, imm 8) → 32'h0020A423 at +0
  - beq (opcode 1100011, rs1 0, rs2 0, imm 8) → 32'h00000463 at +4
  - jal (opcode 1101111, rd 1, imm 2048) → 32'h001000EF at +8
  - three consecutive imem_we cycles.
- Errors: fmt=7 → no write, err=1, ptr unchanged. jal with imm 3 → word written, err stays 1. start clears err.
- Full with IMEM_DEPTH=4: stream 6 tuples → exactly 4 writes (last at +12), in_ready low after the 4th, done=1, inst_count 4.
- Assert rst the cycle after an accept → no imem_we, all outputs 0, state IDLE. finish with a concurrent accept → word written and done in the same cycle.
